spi_mem_bus: RTL

- Memory-side bus slave sitting directly downstream of the CPU core's bus master port.
- Serves each single-byte read/write request by running one full SPI transaction to an external 23LC-style SPI SRAM: 16-bit address, SPI mode 0.
- Returns a one-cycle bus_done pulse to the core; read data is presented alongside that pulse.

---
 rtl/spi_mem_bus.sv | 135 +++++++++++++
 1 files changed

// File: rtl/spi_mem_bus.sv
// spi_mem_bus: single-byte bus slave serving each request with one SPI transaction to a 23LC-style SRAM (mode 0, 16-bit address)
// Ports:
//   clk, rst_n                  system clock, synchronous active-low reset
//   bus_address/bus_data_in     request address and write data from the core
//   bus_read/bus_write          level requests held until bus_done (read wins if both)
//   bus_data_out/bus_done       read data and one-cycle completion pulse
//   spi_cs_n/spi_sclk/spi_mosi  SPI master outputs, all registered
//   spi_miso                    SPI data from memory, sampled on rising sclk
// Optional: define SPI_MEM_LAST_READ_CACHE_EN for a one-entry last-read cache (write-through on address match).
module spi_mem_bus #(
    parameter int         CLK_DIV   = 2,
    parameter logic [7:0] CMD_READ  = 8'h03,
    parameter logic [7:0] CMD_WRITE = 8'h02
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] bus_address,
    input  logic [7:0]  bus_data_in,
    output logic [7:0]  bus_data_out,
    input  logic        bus_read,
    input  logic        bus_write,
    output logic        bus_done,
    output logic        spi_cs_n,
    output logic        spi_sclk,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} state_t;
    state_t        state;
    logic [30:0]   sh;
    logic [7:0]    rx;
    logic [4:0]    bit_cnt;
    logic [DW-1:0] div_cnt;
    logic          rd;
    logic [31:0]   frame;
    logic          hit;
    assign frame = {bus_read ? CMD_READ : CMD_WRITE, bus_address, bus_read ? 8'h00 : bus_data_in};
`ifdef SPI_MEM_LAST_READ_CACHE_EN
    logic        c_valid, hit_pend;
    logic [15:0] c_addr, t_addr;
    logic [7:0]  c_data, t_wdata;
    assign hit = bus_read & c_valid & (c_addr == bus_address);
`else
    assign hit = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            spi_cs_n     <= 1'b1;
            spi_sclk     <= 1'b0;
            spi_mosi     <= 1'b0;
            bus_done     <= 1'b0;
            bus_data_out <= 8'h00;
            sh           <= '0;
            rx           <= '0;
            bit_cnt      <= '0;
            div_cnt      <= '0;
            rd           <= 1'b0;
`ifdef SPI_MEM_LAST_READ_CACHE_EN
            c_valid      <= 1'b0;
            hit_pend     <= 1'b0;
            c_addr       <= '0;
            c_data       <= '0;
            t_addr       <= '0;
            t_wdata      <= '0;
`endif
        end else begin
            case (state)
                IDLE: if (bus_read | bus_write) begin
                    rd      <= bus_read;
                    sh      <= frame[30:0];
                    div_cnt <= '0;
                    bit_cnt <= '0;
                    state   <= SHIFT;
`ifdef SPI_MEM_LAST_READ_CACHE_EN
                    t_addr   <= bus_address;
                    t_wdata  <= bus_data_in;
                    hit_pend <= hit;
`endif
                    if (!hit) begin
                        spi_cs_n <= 1'b0;
                        spi_sclk <= 1'b0;
                        spi_mosi <= frame[31];
                    end
                end
                SHIFT:
`ifdef SPI_MEM_LAST_READ_CACHE_EN
                    if (hit_pend) begin
                        hit_pend     <= 1'b0;
                        bus_done     <= 1'b1;
                        bus_data_out <= c_data;
                        state        <= DONE;
                    end else
`endif
                    if (div_cnt == DW'(CLK_DIV - 1)) begin
                        div_cnt <= '0;
                        if (!spi_sclk) begin
                            spi_sclk <= 1'b1;
                            rx       <= {rx[6:0], spi_miso};
                        end else if (bit_cnt == 5'd31) begin
                            spi_sclk <= 1'b0;
                            spi_cs_n <= 1'b1;
                            bus_done <= 1'b1;
                            state    <= DONE;
                            if (rd) bus_data_out <= rx;
`ifdef SPI_MEM_LAST_READ_CACHE_EN
                            if (rd) begin
                                c_valid <= 1'b1;
                                c_addr  <= t_addr;
                                c_data  <= rx;
                            end else if (c_addr == t_addr) begin
                                c_data  <= t_wdata;
                            end
`endif
                        end else begin
                            spi_sclk <= 1'b0;
                            bit_cnt  <= bit_cnt + 5'd1;
                            spi_mosi <= sh[30];
                            sh       <= {sh[29:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                DONE: begin
                    bus_done <= 1'b0;
                    div_cnt  <= '0;
                    state    <= GAP;
                end
                GAP: if (div_cnt == DW'(CLK_DIV - 1)) state <= IDLE; else div_cnt <= div_cnt + 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
